// File: rtl/avr_operand_access_unit.sv
// Front end of the AVR-subset core: latches the fetched word, decodes it, and
// drives register-file and data-memory controls for the current pipeline stage.
module avr_operand_access_unit #(
  parameter int         INSTR_WIDTH    = 16,
  parameter int         DATA_WIDTH     = 8,
  parameter int         ADDR_WIDTH     = 16,
  parameter int         R_ADDR_WIDTH   = 5,
  parameter logic [7:0] MEM_START_ADDR = 8'h40,
  parameter logic [7:0] MEM_STOP_ADDR  = 8'hBF
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [2:0]              pipeline_stage,
  input  logic [INSTR_WIDTH-1:0]  instruction,
  input  logic [DATA_WIDTH-1:0]   writeback_value,
  input  logic [ADDR_WIDTH-1:0]   indirect_addr,
  input  logic [DATA_WIDTH-1:0]   data_to_store,
  output logic [4:0]              opcode_type,
  output logic [6:0]              opcode_group,
  output logic [R_ADDR_WIDTH-1:0] opcode_rd,
  output logic [R_ADDR_WIDTH-1:0] opcode_rr,
  output logic [11:0]             opcode_imd,
  output logic [2:0]              opcode_bit,
  output logic                    stack_preinc,
  output logic                    stack_postdec,
  output logic [R_ADDR_WIDTH-1:0] rr_addr,
  output logic [R_ADDR_WIDTH-1:0] rd_addr,
  inout  wire  [DATA_WIDTH-1:0]   rr_data,
  inout  wire  [DATA_WIDTH-1:0]   rd_data,
  output logic                    rr_cs,
  output logic                    rd_cs,
  output logic                    rr_we,
  output logic                    rd_we,
  output logic                    rr_oe,
  output logic                    rd_oe,
  output logic [ADDR_WIDTH-1:0]   bus_addr,
  inout  wire  [DATA_WIDTH-1:0]   bus_data,
  output logic                    mem_cs,
  output logic                    mem_we,
  output logic                    mem_oe
);

  localparam logic [4:0] T_NOP = 5'd0,  T_ADD = 5'd1,  T_ADC = 5'd2,  T_SUB = 5'd3,
                         T_AND = 5'd4,  T_EOR = 5'd5,  T_OR  = 5'd6,  T_NEG = 5'd7,
                         T_MOV = 5'd8,  T_LDI = 5'd9,  T_LDS = 5'd10, T_STS = 5'd11,
                         T_LD_X = 5'd12, T_LD_Y = 5'd13, T_LD_Z = 5'd14,
                         T_ST_X = 5'd15, T_ST_Y = 5'd16, T_ST_Z = 5'd17,
                         T_PUSH = 5'd18, T_POP = 5'd19, T_BRBS = 5'd20, T_BRBC = 5'd21,
                         T_RJMP = 5'd22, T_UNKNOWN = 5'd31;

  localparam logic [2:0] S_ID = 3'd1, S_EX = 3'd2, S_MEM = 3'd3, S_WB = 3'd4;

  logic [INSTR_WIDTH-1:0]  instr_buffer;
  logic                    is_alu2, is_ptr, is_load, is_store, writes_rd, in_range;
  logic                    rd_drive, bus_drive;
  logic [R_ADDR_WIDTH-1:0] ptr_lo;
  logic [ADDR_WIDTH-1:0]   mem_addr;
  logic                    unused_inout;

  // IF: instruction latch
  always_ff @(posedge clk) begin
    if (reset)
      instr_buffer <= '0;
    else if (pipeline_stage == 3'd0)
      instr_buffer <= instruction;
  end

  // Decode is purely a function of the latched word
  always_comb begin
    opcode_type = T_UNKNOWN;
    casez (instr_buffer)
      16'b0000_0000_0000_0000: opcode_type = T_NOP;
      16'b0000_11??_????_????: opcode_type = T_ADD;
      16'b0001_11??_????_????: opcode_type = T_ADC;
      16'b0001_10??_????_????: opcode_type = T_SUB;
      16'b0010_00??_????_????: opcode_type = T_AND;
      16'b0010_01??_????_????: opcode_type = T_EOR;
      16'b0010_10??_????_????: opcode_type = T_OR;
      16'b0010_11??_????_????: opcode_type = T_MOV;
      16'b1001_010?_????_0001: opcode_type = T_NEG;
      16'b1110_????_????_????: opcode_type = T_LDI;
      16'b1010_0???_????_????: opcode_type = T_LDS;
      16'b1010_1???_????_????: opcode_type = T_STS;
      16'b1001_000?_????_1100: opcode_type = T_LD_X;
      16'b1000_000?_????_1000: opcode_type = T_LD_Y;
      16'b1000_000?_????_0000: opcode_type = T_LD_Z;
      16'b1001_001?_????_1100: opcode_type = T_ST_X;
      16'b1000_001?_????_1000: opcode_type = T_ST_Y;
      16'b1000_001?_????_0000: opcode_type = T_ST_Z;
      16'b1001_001?_????_1111: opcode_type = T_PUSH;
      16'b1001_000?_????_1111: opcode_type = T_POP;
      16'b1111_00??_????_????: opcode_type = T_BRBS;
      16'b1111_01??_????_????: opcode_type = T_BRBC;
      16'b1100_????_????_????: opcode_type = T_RJMP;
      default:                 opcode_type = T_UNKNOWN;
    endcase

    opcode_rd  = '0;
    opcode_rr  = '0;
    opcode_imd = '0;
    opcode_bit = instr_buffer[2:0];
    case (opcode_type)
      T_ADD, T_ADC, T_SUB, T_AND, T_EOR, T_OR, T_MOV: begin
        opcode_rd = {instr_buffer[8], instr_buffer[7:4]};
        opcode_rr = {instr_buffer[9], instr_buffer[3:0]};
      end
      T_NEG, T_LD_X, T_LD_Y, T_LD_Z, T_POP: opcode_rd = instr_buffer[8:4];
      T_ST_X, T_ST_Y, T_ST_Z, T_PUSH:       opcode_rr = instr_buffer[8:4];
      T_LDI: begin
        opcode_rd  = {1'b1, instr_buffer[7:4]};
        opcode_imd = {4'b0, instr_buffer[11:8], instr_buffer[3:0]};
      end
      T_LDS, T_STS: begin
        if (opcode_type == T_LDS) opcode_rd = {1'b1, instr_buffer[7:4]};
        else                      opcode_rr = {1'b1, instr_buffer[7:4]};
        // Reduced-core 7-bit address maps onto 0x40..0xBF
        opcode_imd = {4'b0, ~instr_buffer[8], instr_buffer[8], instr_buffer[10],
                      instr_buffer[9], instr_buffer[3:0]};
      end
      T_BRBS, T_BRBC: opcode_imd = {{5{instr_buffer[9]}}, instr_buffer[9:3]};
      T_RJMP:         opcode_imd = instr_buffer[11:0];
      default: ;
    endcase

    opcode_group    = '0;
    opcode_group[0] = opcode_type inside {T_ADD, T_ADC, T_SUB, T_AND, T_EOR, T_OR, T_NEG};
    opcode_group[1] = (opcode_type == T_LDS);
    opcode_group[2] = (opcode_type == T_STS);
    opcode_group[3] = opcode_type inside {T_LD_X, T_LD_Y, T_LD_Z, T_POP};
    opcode_group[4] = opcode_type inside {T_ST_X, T_ST_Y, T_ST_Z, T_PUSH};
    opcode_group[5] = opcode_type inside {T_PUSH, T_POP};
    opcode_group[6] = opcode_type inside {T_BRBS, T_BRBC, T_RJMP};
  end

  always_comb begin
    is_alu2   = opcode_type inside {T_ADD, T_ADC, T_SUB, T_AND, T_EOR, T_OR};
    is_ptr    = opcode_type inside {T_LD_X, T_LD_Y, T_LD_Z, T_ST_X, T_ST_Y, T_ST_Z};
    is_load   = opcode_group[1] | opcode_group[3];
    is_store  = opcode_group[2] | opcode_group[4];
    writes_rd = opcode_group[0] | opcode_group[1] | opcode_group[3] |
                (opcode_type inside {T_MOV, T_LDI});
    ptr_lo = 5'd26;
    if (opcode_type inside {T_LD_Y, T_ST_Y}) ptr_lo = 5'd28;
    if (opcode_type inside {T_LD_Z, T_ST_Z}) ptr_lo = 5'd30;
    mem_addr = (opcode_group[1] | opcode_group[2]) ? {8'b0, opcode_imd[7:0]} : indirect_addr;
    in_range = (mem_addr >= ADDR_WIDTH'(MEM_START_ADDR)) &&
               (mem_addr <= ADDR_WIDTH'(MEM_STOP_ADDR));
  end

  // Per-stage port controls; stages 5..7 fall through with everything idle
  always_comb begin
    rd_addr = opcode_rd;
    rr_addr = opcode_rr;
    {rd_cs, rd_oe, rd_we, rr_cs, rr_oe, rr_we} = '0;
    {mem_cs, mem_oe, mem_we} = '0;
    bus_addr      = '0;
    stack_preinc  = 1'b0;
    stack_postdec = 1'b0;
    rd_drive      = 1'b0;
    bus_drive     = 1'b0;
    case (pipeline_stage)
      S_ID: begin
        if (is_alu2 || is_ptr || opcode_type == T_NEG) begin
          rd_cs = 1'b1;
          rd_oe = 1'b1;
        end
        if (is_alu2 || is_ptr || (opcode_type inside {T_MOV, T_STS, T_PUSH})) begin
          rr_cs = 1'b1;
          rr_oe = 1'b1;
        end
        if (is_ptr) begin
          rd_addr = ptr_lo;
          rr_addr = ptr_lo | 5'd1;
        end
      end
      S_EX: begin
        if (opcode_type inside {T_ST_X, T_ST_Y, T_ST_Z}) begin
          rr_cs = 1'b1;
          rr_oe = 1'b1;
        end
        stack_preinc = (opcode_type == T_POP);
      end
      S_MEM: begin
        // Accesses outside the mapped window are dropped silently
        if ((is_load || is_store) && in_range) begin
          mem_cs    = 1'b1;
          mem_oe    = is_load;
          mem_we    = is_store;
          bus_drive = is_store;
          bus_addr  = mem_addr - ADDR_WIDTH'(MEM_START_ADDR);
        end
        stack_postdec = (opcode_type == T_PUSH);
      end
      S_WB: begin
        if (writes_rd) begin
          rd_cs    = 1'b1;
          rd_we    = 1'b1;
          rd_drive = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign rd_data  = rd_drive  ? writeback_value : 'z;
  assign bus_data = bus_drive ? data_to_store   : 'z;
  assign rr_data  = 'z;

  assign unused_inout = ^{rr_data, rd_data, bus_data};

endmodule

// File: tb/tb_avr_operand_access_unit.sv
// Randomized bench for avr_operand_access_unit against an instruction-level model.
module tb_avr_operand_access_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  pipeline_stage;
  logic [15:0] instruction;
  logic [7:0]  writeback_value;
  logic [15:0] indirect_addr;
  logic [7:0]  data_to_store;
  logic [4:0]  opcode_type;
  logic [6:0]  opcode_group;
  logic [4:0]  opcode_rd, opcode_rr, rr_addr, rd_addr;
  logic [11:0] opcode_imd;
  logic [2:0]  opcode_bit;
  logic        stack_preinc, stack_postdec;
  wire  [7:0]  rr_data, rd_data, bus_data;
  logic        rr_cs, rd_cs, rr_we, rd_we, rr_oe, rd_oe;
  logic [15:0] bus_addr;
  logic        mem_cs, mem_we, mem_oe;

  int n_cmp = 0;
  int n_bad = 0;
  bit checking = 1'b0;
  logic [15:0] m_instr;

  avr_operand_access_unit dut (
    .clk(clk), .reset(reset), .pipeline_stage(pipeline_stage), .instruction(instruction),
    .writeback_value(writeback_value), .indirect_addr(indirect_addr),
    .data_to_store(data_to_store), .opcode_type(opcode_type), .opcode_group(opcode_group),
    .opcode_rd(opcode_rd), .opcode_rr(opcode_rr), .opcode_imd(opcode_imd),
    .opcode_bit(opcode_bit), .stack_preinc(stack_preinc), .stack_postdec(stack_postdec),
    .rr_addr(rr_addr), .rd_addr(rd_addr), .rr_data(rr_data), .rd_data(rd_data),
    .rr_cs(rr_cs), .rd_cs(rd_cs), .rr_we(rr_we), .rd_we(rd_we), .rr_oe(rr_oe), .rd_oe(rd_oe),
    .bus_addr(bus_addr), .bus_data(bus_data), .mem_cs(mem_cs), .mem_we(mem_we), .mem_oe(mem_oe)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0]  typ;
    logic [6:0]  grp;
    logic [4:0]  rd, rr;
    logic [11:0] imd;
    logic [2:0]  bitn;
    logic        pre, post;
    logic [4:0]  rd_a, rr_a;
    logic        rd_cs, rd_we, rd_oe, rr_cs, rr_we, rr_oe;
    logic [15:0] baddr;
    logic        mcs, mwe, moe;
    logic [7:0]  rdd, busd;
  } exp_t;

  function automatic int classify(int w);
    if (w == 0) return 0;
    if ((w & 'hFC00) == 'h0C00) return 1;
    if ((w & 'hFC00) == 'h1C00) return 2;
    if ((w & 'hFC00) == 'h1800) return 3;
    if ((w & 'hFC00) == 'h2000) return 4;
    if ((w & 'hFC00) == 'h2400) return 5;
    if ((w & 'hFC00) == 'h2800) return 6;
    if ((w & 'hFE0F) == 'h9401) return 7;
    if ((w & 'hFC00) == 'h2C00) return 8;
    if ((w & 'hF000) == 'hE000) return 9;
    if ((w & 'hF800) == 'hA000) return 10;
    if ((w & 'hF800) == 'hA800) return 11;
    if ((w & 'hFE0F) == 'h900C) return 12;
    if ((w & 'hFE0F) == 'h8008) return 13;
    if ((w & 'hFE0F) == 'h8000) return 14;
    if ((w & 'hFE0F) == 'h920C) return 15;
    if ((w & 'hFE0F) == 'h8208) return 16;
    if ((w & 'hFE0F) == 'h8200) return 17;
    if ((w & 'hFE0F) == 'h920F) return 18;
    if ((w & 'hFE0F) == 'h900F) return 19;
    if ((w & 'hFC00) == 'hF000) return 20;
    if ((w & 'hFC00) == 'hF400) return 21;
    if ((w & 'hF000) == 'hC000) return 22;
    return 31;
  endfunction

  function automatic exp_t predict(int w, int st, int ia, int wb, int dts);
    exp_t e;
    int t, g, d5, d4, k7, addr, base;
    bit alu2, ptr, load, store, wr;
    e = '0;
    t = classify(w);
    d5 = (w >> 4) & 31;
    d4 = 16 + ((w >> 4) & 15);
    e.typ = 5'(t);
    e.bitn = 3'(w & 7);
    if ((t >= 1 && t <= 6) || t == 8) begin
      e.rd = 5'(d5);
      e.rr = 5'((w & 15) | ((w >> 5) & 16));
    end
    if (t == 7 || (t >= 12 && t <= 14) || t == 19) e.rd = 5'(d5);
    if (t >= 15 && t <= 18) e.rr = 5'(d5);
    if (t == 9 || t == 10) e.rd = 5'(d4);
    if (t == 11) e.rr = 5'(d4);
    if (t == 9) e.imd = 12'(((w >> 4) & 'hF0) | (w & 15));
    if (t == 10 || t == 11)
      e.imd = 12'((((w >> 8) & 1) != 0 ? 64 : 128) | (((w >> 10) & 1) << 5) |
                  (((w >> 9) & 1) << 4) | (w & 15));
    if (t == 20 || t == 21) begin
      k7 = (w >> 3) & 127;
      if (k7 >= 64) k7 = k7 - 128;
      e.imd = 12'(k7 & 'hFFF);
    end
    if (t == 22) e.imd = 12'(w & 'hFFF);
    g = 0;
    if (t >= 1 && t <= 7) g = g | 1;
    if (t == 10) g = g | 2;
    if (t == 11) g = g | 4;
    if ((t >= 12 && t <= 14) || t == 19) g = g | 8;
    if (t >= 15 && t <= 18) g = g | 16;
    if (t == 18 || t == 19) g = g | 32;
    if (t >= 20 && t <= 22) g = g | 64;
    e.grp = 7'(g);
    alu2  = (t >= 1 && t <= 6);
    ptr   = (t >= 12 && t <= 17);
    load  = (t == 10) || (t >= 12 && t <= 14) || (t == 19);
    store = (t == 11) || (t >= 15 && t <= 18);
    wr    = (t >= 1 && t <= 10) || (t >= 12 && t <= 14) || (t == 19);
    e.rd_a = e.rd;
    e.rr_a = e.rr;
    if (st == 1) begin
      e.rd_cs = alu2 || t == 7 || ptr;
      e.rd_oe = e.rd_cs;
      e.rr_cs = alu2 || t == 8 || t == 11 || t == 18 || ptr;
      e.rr_oe = e.rr_cs;
      if (ptr) begin
        base = 26 + 2 * ((t - 12) % 3);
        e.rd_a = 5'(base);
        e.rr_a = 5'(base + 1);
      end
    end else if (st == 2) begin
      e.rr_cs = (t >= 15 && t <= 17);
      e.rr_oe = e.rr_cs;
      e.pre   = (t == 19);
    end else if (st == 3) begin
      addr = (t == 10 || t == 11) ? int'(e.imd) : ia;
      if ((load || store) && addr >= 'h40 && addr <= 'hBF) begin
        e.mcs   = 1'b1;
        e.moe   = load;
        e.mwe   = store;
        e.baddr = 16'(addr - 'h40);
        e.busd  = 8'(dts);
      end
      e.post = (t == 18);
    end else if (st == 4 && wr) begin
      e.rd_cs = 1'b1;
      e.rd_we = 1'b1;
      e.rdd   = 8'(wb);
    end
    return e;
  endfunction

  task automatic chk(string name, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got 0x%0h, want 0x%0h (instr 0x%04h stage %0d)",
               name, $time, act, exp, m_instr, pipeline_stage);
    end
  endtask

  always_ff @(posedge clk) begin
    if (reset) m_instr <= 16'h0000;
    else if (pipeline_stage == 3'd0) m_instr <= instruction;
  end

  always @(negedge clk) begin
    exp_t e;
    if (checking) begin
      e = predict(int'(m_instr), int'(pipeline_stage), int'(indirect_addr),
                  int'(writeback_value), int'(data_to_store));
      chk("type", int'(opcode_type), int'(e.typ));
      chk("group", int'(opcode_group), int'(e.grp));
      chk("op_rd", int'(opcode_rd), int'(e.rd));
      chk("op_rr", int'(opcode_rr), int'(e.rr));
      chk("imd", int'(opcode_imd), int'(e.imd));
      chk("bit", int'(opcode_bit), int'(e.bitn));
      chk("preinc", int'(stack_preinc), int'(e.pre));
      chk("postdec", int'(stack_postdec), int'(e.post));
      chk("rd_addr", int'(rd_addr), int'(e.rd_a));
      chk("rr_addr", int'(rr_addr), int'(e.rr_a));
      chk("rd_ctl", int'({rd_cs, rd_we, rd_oe}), int'({e.rd_cs, e.rd_we, e.rd_oe}));
      chk("rr_ctl", int'({rr_cs, rr_we, rr_oe}), int'({e.rr_cs, e.rr_we, e.rr_oe}));
      chk("mem_ctl", int'({mem_cs, mem_we, mem_oe}), int'({e.mcs, e.mwe, e.moe}));
      chk("bus_addr", int'(bus_addr), int'(e.baddr));
      if (e.rd_we) chk("rd_data", int'(rd_data), int'(e.rdd));
      if (e.mwe) chk("bus_data", int'(bus_data), int'(e.busd));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic put(int st);
    pipeline_stage = 3'(st);
    #1;
  endtask

  function automatic logic [15:0] rand_instr();
    int k;
    logic [15:0] r;
    k = $urandom_range(0, 25);
    r = 16'($urandom);
    case (k)
      0:  return 16'h0000;
      1:  return 16'h0C00 | (r & 16'h03FF);
      2:  return 16'h1C00 | (r & 16'h03FF);
      3:  return 16'h1800 | (r & 16'h03FF);
      4:  return 16'h2000 | (r & 16'h03FF);
      5:  return 16'h2400 | (r & 16'h03FF);
      6:  return 16'h2800 | (r & 16'h03FF);
      7:  return 16'h2C00 | (r & 16'h03FF);
      8:  return 16'h9401 | (r & 16'h01F0);
      9:  return 16'hE000 | (r & 16'h0FFF);
      10: return 16'hA000 | (r & 16'h07FF);
      11: return 16'hA800 | (r & 16'h07FF);
      12: return 16'h900C | (r & 16'h01F0);
      13: return 16'h8008 | (r & 16'h01F0);
      14: return 16'h8000 | (r & 16'h01F0);
      15: return 16'h920C | (r & 16'h01F0);
      16: return 16'h8208 | (r & 16'h01F0);
      17: return 16'h8200 | (r & 16'h01F0);
      18: return 16'h920F | (r & 16'h01F0);
      19: return 16'h900F | (r & 16'h01F0);
      20: return 16'hF000 | (r & 16'h03FF);
      21: return 16'hF400 | (r & 16'h03FF);
      22: return 16'hC000 | (r & 16'h0FFF);
      default: return r;
    endcase
  endfunction

  function automatic logic [15:0] rand_ptr();
    case ($urandom_range(0, 5))
      0: return 16'h003F;
      1: return 16'h0040;
      2: return 16'h00BF;
      3: return 16'h00C0;
      4: return 16'($urandom_range(0, 255));
      default: return 16'($urandom);
    endcase
  endfunction

  initial begin
    reset = 1'b1;
    pipeline_stage = 3'd0;
    instruction = 16'h0000;
    writeback_value = 8'h00;
    indirect_addr = 16'h0000;
    data_to_store = 8'h00;
    tick();
    tick();
    reset = 1'b0;
    checking = 1'b1;

    put(1);
    chk("rst_type", int'(opcode_type), 0);
    chk("rst_ctl", int'({rd_cs, rr_cs, mem_cs, rd_we, mem_we}), 0);
    tick();

    instruction = 16'h0C01; put(0); tick();
    chk("add_type", int'(opcode_type), 1);
    chk("add_group", int'(opcode_group), 1);
    put(1);
    chk("add_id_addr", int'({rd_addr, rr_addr}), 1);
    chk("add_id_ctl", int'({rd_cs, rd_oe, rr_cs, rr_oe}), 'hF);
    tick(); put(2); tick(); put(3); tick();
    writeback_value = 8'h55; put(4);
    chk("add_wb_we", int'(rd_we), 1);
    chk("add_wb_data", int'(rd_data), 'h55);
    tick();

    instruction = 16'hEA0B; put(0); tick();
    chk("ldi_type", int'(opcode_type), 9);
    chk("ldi_rd", int'(opcode_rd), 16);
    chk("ldi_imd", int'(opcode_imd), 'h0AB);
    put(3);
    chk("ldi_mem", int'({mem_cs, mem_we, mem_oe}), 0);
    tick();
    writeback_value = 8'h77; put(4);
    chk("ldi_wb", int'({rd_we, rd_addr}), 'h30);
    tick();

    instruction = 16'hA920; put(0); tick();
    chk("sts_type", int'(opcode_type), 11);
    chk("sts_regs", int'({opcode_rd, opcode_rr}), 18);
    chk("sts_imd", int'(opcode_imd), 'h040);
    data_to_store = 8'h3C; put(3);
    chk("sts_mem", int'({mem_cs, mem_we, mem_oe}), 6);
    chk("sts_addr", int'(bus_addr), 0);
    chk("sts_data", int'(bus_data), 'h3C);
    tick();

    instruction = 16'h905C; put(0); tick();
    put(1);
    chk("ldx_ptr", int'({rd_addr, rr_addr}), (26 << 5) | 27);
    tick();
    indirect_addr = 16'h00BF; put(3);
    chk("ldx_top_ctl", int'({mem_cs, mem_oe}), 3);
    chk("ldx_top_addr", int'(bus_addr), 'h7F);
    tick();
    indirect_addr = 16'h00C0; put(3);
    chk("ldx_out_ctl", int'({mem_cs, mem_oe}), 0);
    chk("ldx_out_addr", int'(bus_addr), 0);
    tick();

    instruction = 16'h923F; put(0); tick();
    put(2);
    chk("push_ex", int'({stack_preinc, stack_postdec}), 0);
    tick();
    indirect_addr = 16'h0080; put(3);
    chk("push_mem", int'({stack_postdec, mem_we, mem_cs}), 7);
    tick();

    instruction = 16'h903F; put(0); tick();
    put(2);
    chk("pop_ex", int'(stack_preinc), 1);
    tick();
    indirect_addr = 16'h0081; put(3);
    chk("pop_mem", int'({mem_oe, stack_preinc}), 2);
    tick();
    put(4);
    chk("pop_wb", int'({rd_we, rd_addr}), 'h23);
    tick();

    instruction = 16'hF3F1; put(0); tick();
    chk("brbs_type", int'(opcode_type), 20);
    chk("brbs_imd", int'(opcode_imd), 'hFFE);
    chk("brbs_bit", int'(opcode_bit), 1);
    chk("brbs_group", int'(opcode_group), 'h40);
    for (int s = 1; s < 5; s++) begin
      put(s);
      chk("brbs_ctl", int'({rd_cs, rr_cs, mem_cs, rd_we, mem_we, mem_oe}), 0);
      tick();
    end

    instruction = 16'h0C01; put(0); tick();
    for (int s = 5; s < 8; s++) begin
      put(s);
      chk("idle_stage", int'({rd_cs, rr_cs, mem_cs, rd_we, rd_oe, rr_oe, stack_preinc}), 0);
      tick();
    end
    put(1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("midrst_type", int'(opcode_type), 0);
    chk("midrst_ctl", int'({rd_cs, rr_cs}), 0);
    tick();

    for (int n = 0; n < 1500; n++) begin
      instruction = rand_instr();
      for (int s = 0; s < 5; s++) begin
        pipeline_stage = 3'(s);
        if ($urandom_range(0, 15) == 0) pipeline_stage = 3'($urandom_range(0, 7));
        reset = ($urandom_range(0, 63) == 0);
        writeback_value = 8'($urandom);
        data_to_store = 8'($urandom);
        indirect_addr = rand_ptr();
        tick();
      end
    end
    reset = 1'b0;
    tick();
    checking = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/avr_operand_access_unit.md
Name: avr_operand_access_unit

Overview:
Front end of the 5-stage AVR-subset core. Latches the fetched instruction, decodes it, and drives the register-file port controls and the data-memory bus controls for the current pipeline stage. The surrounding controller owns the PC, SREG, SP, ALU buffers and writeback value.

Parameters:
INSTR_WIDTH, 16, instruction width
DATA_WIDTH, 8, register/data width
ADDR_WIDTH, 16, data address width
R_ADDR_WIDTH, 5, register index width (32 regs)
MEM_START_ADDR, 8'h40, first mapped RAM address
MEM_STOP_ADDR, 8'hBF, last mapped RAM address

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
pipeline_stage  in  3  0=IF 1=ID 2=EX 3=MEM 4=WB
instruction  in  16  word from instruction ROM
writeback_value  in  8  value written to Rd in WB
indirect_addr  in  16  X/Y/Z pointer or {8'b0,SP}
data_to_store  in  8  store data
opcode_type  out  5  decoded type code
opcode_group  out  7  one-hot group flags
opcode_rd, opcode_rr  out  5 each  decoded register indices
opcode_imd  out  12  decoded immediate
opcode_bit  out  3  SREG bit for BRBS/BRBC
stack_preinc, stack_postdec  out  1 each  SP update strobes
rr_addr, rd_addr  out  5 each  register-file addresses
rr_data, rd_data  inout  8 each  register-file data
rr_cs, rd_cs, rr_we, rd_we, rr_oe, rd_oe  out  1 each  register-file port controls
bus_addr  out  16  RAM-relative address
bus_data  inout  8  memory data
mem_cs, mem_we, mem_oe  out  1 each  memory controls

Behaviour:
- instr_buffer loads instruction on clk edge while stage==IF. Reset loads 0 (NOP). Decode and all controls are combinational from instr_buffer and stage.
- Type codes: NOP0 ADD1 ADC2 SUB3 AND4 EOR5 OR6 NEG7 MOV8 LDI9 LDS10 STS11 LD_X12 LD_Y13 LD_Z14 ST_X15 ST_Y16 ST_Z17 PUSH18 POP19 BRBS20 BRBC21 RJMP22 UNKNOWN31.
- Encodings (standard AVR):
  - ADD 000011; ADC 000111; SUB 000110; AND 001000; EOR 001001; OR 001010; MOV 001011. For these, rd={i[8],i[7:4]} and rr={i[9],i[3:0]}.
  - NEG: 1001010ddddd0001.
  - LDI: 1110KKKKddddKKKK, rd=16+d.
  - LDS/STS (reduced core): 10100/10101 kkk dddd kkkk; addr8={~i[8],i[8],i[10],i[9],i[3:0]}.
  - LD: X 1001000d_dddd1100; Y 1000000d_dddd1000; Z 1000000d_dddd0000. ST: same with bit9=1. POP 1001000d_dddd1111; PUSH 1001001r_rrrr1111.
  - BRBS 111100kkkkkkksss; BRBC 111101kkkkkkksss; RJMP 1100 k12; NOP 0x0000. Anything else is UNKNOWN.
- For STS/ST/PUSH, opcode_rr = the encoded register and opcode_rd = 0.
- opcode_imd: LDI {4'b0,K}; LDS/STS {4'b0,addr8}; BRBS/BRBC k7 sign-extended; RJMP k12; otherwise 0. opcode_bit = i[2:0].
- Groups: [0] ALU (ADD..NEG); [1] LOAD_DIRECT (LDS); [2] STORE_DIRECT (STS); [3] LOAD_INDIRECT (LD*, POP); [4] STORE_INDIRECT (ST*, PUSH); [5] STACK (PUSH, POP); [6] BRANCH.
- Register file (read = cs=1, oe=1, we=0; write = cs=1, we=1, oe=0):
  - ID, two-operand ALU: read rd_addr=opcode_rd and rr_addr=opcode_rr. NEG: rd port only. MOV, STS, PUSH: rr port only.
  - ID, LD/ST X/Y/Z: read pointer pair. rd_addr=26/28/30 (low), rr_addr=27/29/31 (high).
  - EX, ST X/Y/Z: rr port reads opcode_rr (store data).
  - WB, ALU/MOV/LDI/LDS/LD*/POP: rd port writes writeback_value to opcode_rd; rd_data is driven only then.
  - This block never drives rr_data/rd_data except the WB write, else Z. Unused controls are 0; addresses otherwise follow opcode_rd/opcode_rr.
- Memory (MEM stage only):
  - Address is {8'b0,addr8} for direct access, indirect_addr for indirect/stack.
  - Address in [MEM_START_ADDR, MEM_STOP_ADDR] (inclusive): mem_cs=1 and bus_addr = address − MEM_START_ADDR.
  - Loads: mem_oe=1. Stores: mem_we=1, bus_data driven with data_to_store.
  - Out of range: cs/we/oe=0, bus_addr=0; the access is silently dropped.
  - bus_data is Z whenever not writing.
- stack_preinc=1 in EX for POP; stack_postdec=1 in MEM for PUSH; else 0.
- stage values 5–7: every control 0, all inout Z.
- Reset asserted mid-instruction: next cycle decodes NOP with all controls 0.

Test Plan:
- Reset, then IF with 0x0C01 (ADD r0,r1) → type 1, group 7'b0000001; ID: rd_addr 0, rr_addr 1, both cs/oe=1; WB, writeback_value 0x55: rd_we=1, rd_data=0x55.
- LDI r16,0xAB (0xEA0B) → type 9, rd 16, imd 0x0AB; WB rd_we=1 to addr 16; no memory activity.
- STS 0x40 via 0xA800-form encoding addr8=0x40, data_to_store 0x3C → MEM: mem_cs=1, mem_we=1, bus_addr 0, bus_data 0x3C.
- LD r5,X with indirect_addr 0x00BF → ID reads r26/r27; MEM mem_oe=1, bus_addr 0x7F. Repeat with 0x00C0 → mem_cs=0.
- PUSH r3 → EX no strobe, MEM stack_postdec=1 and mem_we=1; POP r3 → EX stack_preinc=1, MEM mem_oe=1, WB rd_we=1.
- BRBS bit 1, k=−2 (0xF3F1) → type 20, imd 0xFFE, bit 1, group BRANCH; no register or memory controls in any stage.
